result_deserializer: RTL and testbench
======================================

// Module: result_deserializer
// PURPOSE
//   Downstream consumer of the 1-bit combinational result stream from the inverter/AND stage.
//   Collects WIDTH accepted bits into a word and presents it on a valid/ready output port.
//   Internally double-buffered: a shift register plus one output register.
//   Gives the dataflow testbench a sequential sink: flops, an FSM, a counter and back-pressure.
// PARAMETERS
//   WIDTH      8  bits per assembled word; legal range 2..32
//   MSB_FIRST  0  0: first accepted bit lands in bit 0; 1: first accepted bit lands in bit WIDTH-1
//   CNT_W      8  width of the emitted-word counter
// PORTS
//   clk         input   1      sole clock; all state updates on posedge
//   rst         input   1      synchronous, active-high reset
//   in_bit      input   1      serial data bit (the upstream result)
//   in_valid    input   1      in_bit is valid this cycle
//   in_ready    output  1      block accepts in_bit this cycle
//   out_word    output  WIDTH  assembled word
//   out_valid   output  1      out_word holds an unconsumed word
//   out_ready   input   1      downstream consumes out_word this cycle
//   word_count  output  CNT_W  number of words consumed downstream, modulo 2^CNT_W
//   busy        output  1      shift register holds at least one bit, or FSM is in HOLD
// BEHAVIOUR
//   Clocking and reset
//   - One clock domain. Reset is synchronous and active-high and dominates all other inputs.
//   - Reset values: out_word=0, out_valid=0, word_count=0, busy=0, in_ready=1.
//   - Internal reset state: FSM=COLLECT, bit count=0, shift register=0.
//   Handshakes
//   - Input accept = in_valid & in_ready. Output consume = out_valid & out_ready.
//   - in_ready is a function of FSM state only; it has no combinational path from out_ready.
//   - out_word and out_valid come straight from flops.
//   - out_word stays stable while out_valid=1 and out_ready=0.
//   FSM states
//   - COLLECT: in_ready=1.
//     - On accept, write in_bit into the slot given by the bit count, then increment the count.
//     - If the accepted bit is the WIDTH-th bit and the output register is free, move to the
//       output register next cycle. Free means out_valid=0, or a consume happens this cycle.
//       On that move: out_word gets the full word, out_valid=1, count=0, FSM stays in COLLECT.
//     - If the accepted bit is the WIDTH-th bit and the output register is not free, go to HOLD.
//       The count stays at WIDTH.
//   - HOLD: in_ready=0; the shift register is frozen.
//     - On a consume: the held word loads into out_word on the same edge, out_valid stays 1,
//       count=0, FSM returns to COLLECT.
//   Latency and throughput
//   - Last bit accepted in cycle N gives out_valid=1 in cycle N+1, when the output register is free.
//   - With out_ready held at 1, sustained throughput is 1 bit/cycle with no bubbles.
//   Counter and width rules
//   - word_count increments by 1 on every consume and wraps from 2^CNT_W-1 to 0.
//   - Bit slots not yet written in the shift register are 0. The bit count is clog2(WIDTH+1) bits.
//   Boundary conditions
//   - in_valid=0 leaves all state unchanged except for a consume.
//   - A consume and a last-bit accept in the same cycle: the new word replaces the old one.
//     out_valid stays 1 and word_count increments.
//   - Reset in the middle of a word discards the partial bits and any held or pending word.
//     No output handshake happens in the reset cycle.
//   - out_ready while out_valid=0 has no effect.
// TESTING
//   1 WIDTH=8, MSB_FIRST=0, out_ready=1; bits 1,0,1,0,0,1,0,1 on consecutive cycles
//     -> out_word=8'hA5, out_valid=1 exactly one cycle after the 8th bit.
//   2 MSB_FIRST=1, same bit sequence -> out_word=8'hA5 reversed = 8'hA5 (palindrome).
//     Then send 1,0,0,0,0,0,0,0 -> out_word=8'h80.
//   3 out_ready=0; stream 16 bits (8'hFF then 8'h0F, LSB-first)
//     -> out_word holds 8'hFF, FSM enters HOLD, in_ready=0, in_valid ignored.
//     -> Raise out_ready for one cycle: next out_word=8'h0F, out_valid=1, in_ready=1.
//   4 out_ready=1 constant; 64 continuous bits -> 8 words, no in_ready deassertion, word_count=8.
//   5 Assert rst after 5 bits of a word -> next cycle out_valid=0, busy=0, word_count=0.
//     -> A following full 8-bit word decodes correctly with no stale bits.
//   6 CNT_W=2; 5 consumed words -> word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/result_deserializer.sv
// rtl/result_deserializer.sv - serial result bits to word deserializer with valid/ready output
//
// Purpose:
//   Collects WIDTH accepted serial bits into a word and offers it on a valid/ready port.
//   Double-buffered: the shift register keeps collecting while out_word waits to be consumed.
//   A completed word that cannot move to the output register parks in the shift register
//   (HOLD) until the current output word is consumed.
//
// Ports:
//   clk         sole clock, all state updates on posedge
//   rst         synchronous active-high reset, dominates all other inputs
//   in_bit      serial data bit
//   in_valid    in_bit is valid this cycle
//   in_ready    block accepts in_bit this cycle (depends on FSM state only)
//   out_word    assembled word (registered)
//   out_valid   out_word holds an unconsumed word (registered)
//   out_ready   downstream consumes out_word this cycle
//   word_count  words consumed downstream, modulo 2^CNT_W
//   busy        shift register holds at least one bit, or FSM is in HOLD

module result_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  localparam int BCW = $clog2(WIDTH + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bcnt;
  logic [WIDTH-1:0] next_word;
  logic             accept;
  logic             consume;
  logic             last_bit;
  logic             out_free;

  assign in_ready = (state == COLLECT);
  assign busy     = (bcnt != '0) || (state == HOLD);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign last_bit = (bcnt == BCW'(WIDTH - 1));
  // The output register can take a new word if it is empty or being drained this cycle.
  assign out_free = !out_valid || out_ready;

  // Shift register contents with the incoming bit dropped into its slot.
  always_comb begin
    next_word = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (bcnt == BCW'(MSB_FIRST ? (WIDTH - 1 - i) : i)) begin
        next_word[i] = in_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      shreg      <= '0;
      bcnt       <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      if (consume) begin
        word_count <= word_count + 1'b1;
        out_valid  <= 1'b0;
      end

      case (state)
        COLLECT: begin
          if (accept) begin
            if (last_bit && out_free) begin
              // Word goes straight to the output; shift register restarts clean.
              out_word  <= next_word;
              out_valid <= 1'b1;
              shreg     <= '0;
              bcnt      <= '0;
            end else begin
              shreg <= next_word;
              bcnt  <= bcnt + 1'b1;
              if (last_bit) begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (consume) begin
            out_word  <= shreg;
            out_valid <= 1'b1;
            shreg     <= '0;
            bcnt      <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_result_deserializer.sv
// tb/tb_result_deserializer.sv - directed self-checking bench for result_deserializer

module tb_result_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, in_ready1, in_ready2;
  logic [7:0] out_word0, out_word1, out_word2;
  logic       out_valid0, out_valid1, out_valid2;
  logic [7:0] word_count0, word_count1;
  logic [1:0] word_count2;
  logic       busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;
  logic       ready_dropped;
  logic [7:0] pat;

  always #5 clk = ~clk;

  result_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready0),
    .out_word(out_word0), .out_valid(out_valid0), .out_ready(out_ready),
    .word_count(word_count0), .busy(busy0)
  );

  result_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready1),
    .out_word(out_word1), .out_valid(out_valid1), .out_ready(out_ready),
    .word_count(word_count1), .busy(busy1)
  );

  result_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready2),
    .out_word(out_word2), .out_valid(out_valid2), .out_ready(out_ready),
    .word_count(word_count2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends w[0] first, w[7] last on consecutive cycles; returns one cycle after the last bit.
  task automatic feed(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = w[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_word", out_word0, 8'h00);
    check("rst_word_count", word_count0, 0);
    check("rst_busy", busy0, 0);
    check("rst_in_ready", in_ready0, 1);
    rst = 1'b0;

    // 1: LSB-first A5, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = pat_bit(8'hA5, i);
    end
    @(negedge clk);
    check("t1_valid_before_last", out_valid0, 0);
    in_bit = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_valid", out_valid0, 1);
    check("t1_word", out_word0, 8'hA5);
    check("t2_msb_word_a5", out_word1, 8'hA5);
    check("t1_busy_idle", busy0, 0);
    @(negedge clk);
    check("t1_consumed", out_valid0, 0);
    check("t1_count", word_count0, 1);

    // 2: MSB-first 1,0,0,0,0,0,0,0
    feed(8'h01);
    check("t2_msb_word_80", out_word1, 8'h80);
    check("t2_lsb_word_01", out_word0, 8'h01);
    @(negedge clk);
    check("t2_count", word_count0, 2);

    // 3: back-pressure into HOLD
    out_ready = 1'b0;
    feed(8'hFF);
    check("t3_first_valid", out_valid0, 1);
    check("t3_first_word", out_word0, 8'hFF);
    feed(8'h0F);
    check("t3_hold_in_ready", in_ready0, 0);
    check("t3_hold_busy", busy0, 1);
    check("t3_hold_word", out_word0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    check("t3_ignored_word", out_word0, 8'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_release_word", out_word0, 8'h0F);
    check("t3_release_valid", out_valid0, 1);
    check("t3_release_in_ready", in_ready0, 1);
    check("t3_release_busy", busy0, 0);
    check("t3_release_count", word_count0, 3);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_drain_count", word_count0, 4);
    check("t3_drain_valid", out_valid0, 0);

    // 4: 64 continuous bits with out_ready held high
    ready_dropped = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (!in_ready0) ready_dropped = 1'b1;
        if (i == 0 && k > 0) begin
          pat = 8'h1D + 8'(37 * (k - 1));
          check("t4_stream_word", out_word0, {24'h0, pat});
          check("t4_stream_valid", out_valid0, 1);
        end
        pat      = 8'h1D + 8'(37 * k);
        in_valid = 1'b1;
        in_bit   = pat[i];
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    pat = 8'h1D + 8'(37 * 7);
    check("t4_last_word", out_word0, {24'h0, pat});
    @(negedge clk);
    check("t4_no_ready_drop", ready_dropped, 0);
    check("t4_count", word_count0, 12);
    check("t4_count_w2", word_count2, 0);

    // 5: reset mid-word with a pending output word
    out_ready = 1'b0;
    feed(8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_busy_partial", busy0, 1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", out_valid0, 0);
    check("t5_rst_busy", busy0, 0);
    check("t5_rst_count", word_count0, 0);
    check("t5_rst_word", out_word0, 8'h00);
    feed(8'h96);
    check("t5_clean_word", out_word0, 8'h96);

    // 6: 2-bit counter wrap; the 0x96 word is the first consume
    @(negedge clk);
    check("t6_wc_1", word_count2, 1);
    feed(8'h11); @(negedge clk); check("t6_wc_2", word_count2, 2);
    feed(8'h22); @(negedge clk); check("t6_wc_3", word_count2, 3);
    feed(8'h33); @(negedge clk); check("t6_wc_0", word_count2, 0);
    feed(8'h44); @(negedge clk); check("t6_wc_1b", word_count2, 1);
    check("t6_wc_full", word_count0, 5);

    // 7: consume and last-bit accept in the same cycle
    out_ready = 1'b0;
    feed(8'hC3);
    check("t7_old_word", out_word0, 8'hC3);
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_bit    = pat[i];
      out_ready = (i == 7);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t7_new_word", out_word0, 8'h5A);
    check("t7_valid", out_valid0, 1);
    check("t7_in_ready", in_ready0, 1);
    check("t7_count", word_count0, 6);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t7_drain_count", word_count0, 7);
    check("t7_drain_valid", out_valid0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic pat_bit(input logic [7:0] w, input int i);
    return w[i];
  endfunction

endmodule
